// File: rtl/fd_m_seq_ctrl_if.sv
// Ratio configuration handshake between a host and the divide-by-M sequencer.
// cfg_err is a one-cycle report that a zero ratio was offered and discarded.
interface fd_m_seq_ctrl_if #(
    parameter int CNT_W = 2
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_m;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_m,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_m,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/fd_m_seq_ctrl.sv
// Divide-by-M feedback divider sequencer: phase counter, glitch-free ratio updates at
// period boundaries, and a stable flag after SETTLE_PER whole periods.
module fd_m_seq_ctrl #(
    parameter int CNT_W      = 2,
    parameter int DEFAULT_M  = 2,
    parameter int SETTLE_PER = 2
) (
    input  logic                 clk_ext,
    input  logic                 rst,
    input  logic                 enable,
    fd_m_seq_ctrl_if.slave       cfg,
    output logic [CNT_W-1:0]     M,
    output logic [CNT_W-1:0]     M_counter,
    output logic                 wrap,
    output logic                 stable
);
    localparam int SW = (SETTLE_PER > 1) ? $clog2(SETTLE_PER) : 1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_PER - 1);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] M_RST       = CNT_W'(DEFAULT_M);

    typedef enum logic [1:0] {IDLE, SETTLE, RUN, PEND} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             stable_q, stable_d;
    logic             err_q, err_d;

    logic             xfer, legal, change;

    assign cfg.cfg_ready = (state_q != PEND);
    assign cfg.cfg_err   = err_q;
    assign M             = m_q;
    assign M_counter     = cnt_q;
    assign stable        = stable_q;
    assign wrap          = (state_q != IDLE) && (cnt_q == (m_q - ONE));

    assign xfer   = cfg.cfg_valid && cfg.cfg_ready;
    assign legal  = xfer && (cfg.cfg_m != '0);
    assign change = legal && (cfg.cfg_m != m_q);

    always_ff @(posedge clk_ext) begin
        if (rst) begin
            state_q  <= IDLE;
            m_q      <= M_RST;
            cnt_q    <= '0;
            shadow_q <= '0;
            settle_q <= '0;
            stable_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            settle_q <= settle_d;
            stable_q <= stable_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        settle_d = settle_q;
        stable_d = stable_q;
        err_d    = xfer && (cfg.cfg_m == '0);

        if (state_q == IDLE) begin
            cnt_d    = '0;
            stable_d = 1'b0;
            if (legal) m_d = cfg.cfg_m;
            if (enable) begin
                state_d  = SETTLE;
                settle_d = '0;
            end
        end else begin
            cnt_d = wrap ? '0 : cnt_q + ONE;
            if (!enable) begin
                // Leaving for IDLE still honours whatever ratio was already accepted.
                state_d  = IDLE;
                cnt_d    = '0;
                stable_d = 1'b0;
                if (state_q == PEND) m_d = shadow_q;
                else if (legal)      m_d = cfg.cfg_m;
            end else if (state_q == PEND) begin
                if (wrap) begin
                    m_d      = shadow_q;
                    cnt_d    = '0;
                    settle_d = '0;
                    stable_d = 1'b0;
                    state_d  = SETTLE;
                end
            end else if (change && wrap) begin
                // Boundary already here: apply directly, no PEND detour.
                m_d      = cfg.cfg_m;
                cnt_d    = '0;
                settle_d = '0;
                stable_d = 1'b0;
                state_d  = SETTLE;
            end else if (change) begin
                shadow_d = cfg.cfg_m;
                state_d  = PEND;
            end else if (state_q == SETTLE && wrap) begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = RUN;
                    stable_d = 1'b1;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fd_m_seq_ctrl.sv
// Directed bench for fd_m_seq_ctrl (CNT_W=2, DEFAULT_M=2, SETTLE_PER=2).
module tb_fd_m_seq_ctrl;
    logic       clk_ext = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] M, M_counter;
    logic       wrap, stable;
    int         checks   = 0;
    int         failures = 0;

    fd_m_seq_ctrl_if #(.CNT_W(2)) cfg ();

    fd_m_seq_ctrl #(.CNT_W(2), .DEFAULT_M(2), .SETTLE_PER(2)) dut (
        .clk_ext   (clk_ext),
        .rst       (rst),
        .enable    (enable),
        .cfg       (cfg.slave),
        .M         (M),
        .M_counter (M_counter),
        .wrap      (wrap),
        .stable    (stable)
    );

    always #5 clk_ext = ~clk_ext;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_ext);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [1:0] m);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_m     = m;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; cfg.cfg_valid = 1'b0; cfg.cfg_m = 2'd0;
        cyc(2);
        chk("rst_M", 8'(M), 8'd2);
        chk("rst_cnt", 8'(M_counter), 8'd0);
        chk("rst_ready", 8'(cfg.cfg_ready), 8'd1);
        chk("rst_err", 8'(cfg.cfg_err), 8'd0);
        chk("rst_stable", 8'(stable), 8'd0);
        chk("rst_wrap", 8'(wrap), 8'd0);
        rst = 1'b0;

        // start-up settle with M=2
        enable = 1'b1;
        cyc(1); chk("st_cnt0", 8'(M_counter), 8'd0); chk("st_wrap0", 8'(wrap), 8'd0);
        cyc(1); chk("st_cnt1", 8'(M_counter), 8'd1); chk("st_wrap1", 8'(wrap), 8'd1);
        cyc(1); chk("st_cnt2", 8'(M_counter), 8'd0); chk("st_stab2", 8'(stable), 8'd0);
        cyc(1); chk("st_cnt3", 8'(M_counter), 8'd1); chk("st_stab3", 8'(stable), 8'd0);
        cyc(1); chk("st_cnt4", 8'(M_counter), 8'd0); chk("st_stab4", 8'(stable), 8'd1);

        // RUN, mid-period offer of 3 -> PEND until wrap
        offer(2'd3);
        chk("pe_ready_pre", 8'(cfg.cfg_ready), 8'd1);
        cyc(1); cfg.cfg_valid = 1'b0;
        chk("pe_ready", 8'(cfg.cfg_ready), 8'd0);
        chk("pe_M_old", 8'(M), 8'd2);
        chk("pe_wrap", 8'(wrap), 8'd1);
        chk("pe_stable", 8'(stable), 8'd1);
        cyc(1);
        chk("pe_M_new", 8'(M), 8'd3);
        chk("pe_cnt", 8'(M_counter), 8'd0);
        chk("pe_ready_post", 8'(cfg.cfg_ready), 8'd1);
        chk("pe_stab_post", 8'(stable), 8'd0);
        cyc(1); chk("m3_cnt1", 8'(M_counter), 8'd1);
        cyc(1); chk("m3_cnt2", 8'(M_counter), 8'd2); chk("m3_wrap", 8'(wrap), 8'd1);
        cyc(3); chk("m3_stab_p2", 8'(stable), 8'd0); chk("m3_cnt2b", 8'(M_counter), 8'd2);
        cyc(1); chk("m3_stab_run", 8'(stable), 8'd1); chk("m3_cnt0", 8'(M_counter), 8'd0);

        // offer in the wrap cycle: applied directly
        cyc(2); offer(2'd2);
        cyc(1); cfg.cfg_valid = 1'b0;
        chk("wa_M2", 8'(M), 8'd2); chk("wa_cnt", 8'(M_counter), 8'd0);
        chk("wa_ready", 8'(cfg.cfg_ready), 8'd1); chk("wa_stab", 8'(stable), 8'd0);
        cyc(4); chk("wa_stab_run", 8'(stable), 8'd1);
        cyc(1); offer(2'd3);
        chk("wb_wrap", 8'(wrap), 8'd1); chk("wb_ready", 8'(cfg.cfg_ready), 8'd1);
        cyc(1); cfg.cfg_valid = 1'b0;
        chk("wb_M3", 8'(M), 8'd3); chk("wb_cnt", 8'(M_counter), 8'd0);
        chk("wb_ready_post", 8'(cfg.cfg_ready), 8'd1);

        // zero ratio discarded, equal ratio is a no-op
        cyc(6); chk("z_stab", 8'(stable), 8'd1); chk("z_cnt0", 8'(M_counter), 8'd0);
        offer(2'd0);
        cyc(1); cfg.cfg_valid = 1'b0;
        chk("z_err", 8'(cfg.cfg_err), 8'd1); chk("z_M", 8'(M), 8'd3);
        chk("z_cnt1", 8'(M_counter), 8'd1); chk("z_stab1", 8'(stable), 8'd1);
        cyc(1); chk("z_err_clr", 8'(cfg.cfg_err), 8'd0); chk("z_cnt2", 8'(M_counter), 8'd2);
        cyc(1); offer(2'd3);
        cyc(1); cfg.cfg_valid = 1'b0;
        chk("eq_ready", 8'(cfg.cfg_ready), 8'd1); chk("eq_stab", 8'(stable), 8'd1);
        chk("eq_M", 8'(M), 8'd3); chk("eq_err", 8'(cfg.cfg_err), 8'd0);

        // ratio 1: counter held at 0, wrap every cycle
        offer(2'd1);
        cyc(1); cfg.cfg_valid = 1'b0;
        chk("m1_pend", 8'(cfg.cfg_ready), 8'd0); chk("m1_cnt2", 8'(M_counter), 8'd2);
        cyc(1); chk("m1_M", 8'(M), 8'd1); chk("m1_cnt_a", 8'(M_counter), 8'd0);
        chk("m1_wrap_a", 8'(wrap), 8'd1); chk("m1_stab_a", 8'(stable), 8'd0);
        cyc(1); chk("m1_cnt_b", 8'(M_counter), 8'd0); chk("m1_stab_b", 8'(stable), 8'd0);
        cyc(1); chk("m1_stab_c", 8'(stable), 8'd1); chk("m1_wrap_c", 8'(wrap), 8'd1);

        // reset while PEND with shadow 3
        offer(2'd2);
        cyc(1); cfg.cfg_valid = 1'b0; chk("r_M2", 8'(M), 8'd2);
        offer(2'd3);
        cyc(1); cfg.cfg_valid = 1'b0; chk("r_pend", 8'(cfg.cfg_ready), 8'd0);
        rst = 1'b1;
        cyc(1); rst = 1'b0;
        chk("r_M", 8'(M), 8'd2); chk("r_cnt", 8'(M_counter), 8'd0);
        chk("r_ready", 8'(cfg.cfg_ready), 8'd1); chk("r_wrap_idle", 8'(wrap), 8'd0);
        cyc(1); chk("r_M_after", 8'(M), 8'd2);

        // enable=0 while PEND at its wrap cycle
        offer(2'd3);
        cyc(1); cfg.cfg_valid = 1'b0; enable = 1'b0;
        chk("e_pend", 8'(cfg.cfg_ready), 8'd0); chk("e_wrap", 8'(wrap), 8'd1);
        cyc(1);
        chk("e_M", 8'(M), 8'd3); chk("e_cnt", 8'(M_counter), 8'd0);
        chk("e_ready", 8'(cfg.cfg_ready), 8'd1); chk("e_stab", 8'(stable), 8'd0);
        cyc(1); chk("e_idle_cnt", 8'(M_counter), 8'd0); chk("e_idle_wrap", 8'(wrap), 8'd0);

        // IDLE loads ratio directly
        offer(2'd1);
        cyc(1); cfg.cfg_valid = 1'b0; chk("i_M1", 8'(M), 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
